gpr_wb_arbiter: RTL and testbench

//   Write-back initiator for the GPRs register file: merges results from the single-cycle ALU,
//   the multi-cycle MUL/DIV unit and the encryption accelerator into the GPRs single write port
//   (rd_add / data_write / write_en). Tracks destination registers of in-flight multi-cycle ops
//   in a busy scoreboard that the hazard unit reads. Sits between EX/accelerator outputs and GPRs.

---
 rtl/gpr_wb_arbiter_pkg.sv | 20 ++
 rtl/gpr_scoreboard.sv | 38 +++
 rtl/gpr_wb_arbiter.sv | 140 ++++++++++++++
 tb/tb_gpr_wb_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared core definitions for GPR write-back arbitration.
// Widths and the write-back source encoding.
package gpr_wb_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MD,
        WB_ACC
    } wb_src_e;

    typedef enum logic {
        RR_MD,
        RR_ACC
    } rr_e;

endpackage

// File: rtl/gpr_scoreboard.sv
// Busy scoreboard for GPRs awaiting multi-cycle results.
// A set and a clear of the same register in one cycle leaves it busy.
module gpr_scoreboard
    import gpr_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_set_valid,
    input  logic [REG_ADDR_W-1:0] i_set_rd,
    input  logic                  i_clr_valid,
    input  logic [REG_ADDR_W-1:0] i_clr_rd,
    output logic [NUM_REGS-1:0]   o_busy
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;
    logic [NUM_REGS-1:0] w_next;

    // Decode set/clear masks; set applied after clear so it wins; x0 never busy.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_set_valid) w_set[i_set_rd] = 1'b1;
        if (i_clr_valid) w_clr[i_clr_rd] = 1'b1;
        w_next    = (r_busy & ~w_clr) | w_set;
        w_next[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_next;
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Write-back arbiter driving the single GPR write port.
// ALU has fixed priority; MUL/DIV and accelerator share round-robin.
module gpr_wb_arbiter
    import gpr_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_wb_valid,
    input  logic [REG_ADDR_W-1:0] alu_wb_rd,
    input  logic [XLEN-1:0]       alu_wb_data,
    input  logic                  md_wb_valid,
    output logic                  md_wb_ready,
    input  logic [REG_ADDR_W-1:0] md_wb_rd,
    input  logic [XLEN-1:0]       md_wb_data,
    input  logic                  acc_wb_valid,
    output logic                  acc_wb_ready,
    input  logic [REG_ADDR_W-1:0] acc_wb_rd,
    input  logic [XLEN-1:0]       acc_wb_data,
    input  logic                  mark_valid,
    input  logic [REG_ADDR_W-1:0] mark_rd,
    output logic [NUM_REGS-1:0]   gpr_busy,
    output logic [REG_ADDR_W-1:0] rd_add,
    output logic [XLEN-1:0]       data_write,
    output logic                  write_en
);

    rr_e                   r_rr_ptr;
    logic                  w_md_hs;
    logic                  w_acc_hs;
    logic                  w_win;
    wb_src_e               w_src;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [XLEN-1:0]       w_data;
    logic                  w_we;
    logic                  w_clr_valid;
    logic [REG_ADDR_W-1:0] w_clr_rd;

    logic                  r_md_hold;
    logic [REG_ADDR_W-1:0] r_md_rd;
    logic [XLEN-1:0]       r_md_data;
    logic                  r_acc_hold;
    logic [REG_ADDR_W-1:0] r_acc_rd;
    logic [XLEN-1:0]       r_acc_data;

    assign md_wb_ready  = ~rst & ~alu_wb_valid
                        & ((r_rr_ptr == RR_MD) | ~acc_wb_valid);
    assign acc_wb_ready = ~rst & ~alu_wb_valid
                        & ((r_rr_ptr == RR_ACC) | ~md_wb_valid);

    assign w_md_hs  = md_wb_valid & md_wb_ready;
    assign w_acc_hs = acc_wb_valid & acc_wb_ready;

    // Pick the winning source and its destination/result.
    always_comb begin
        w_win  = alu_wb_valid | w_md_hs | w_acc_hs;
        w_src  = WB_ALU;
        w_rd   = '0;
        w_data = '0;
        if (!alu_wb_valid && w_md_hs)       w_src = WB_MD;
        else if (!alu_wb_valid && w_acc_hs) w_src = WB_ACC;
        unique case (w_src)
            WB_MD: begin
                w_rd   = md_wb_rd;
                w_data = md_wb_data;
            end
            WB_ACC: begin
                w_rd   = acc_wb_rd;
                w_data = acc_wb_data;
            end
            default: begin
                w_rd   = alu_wb_rd;
                w_data = alu_wb_data;
            end
        endcase
    end

    assign w_we        = w_win & (w_rd != '0);
    assign w_clr_valid = w_md_hs | w_acc_hs;
    assign w_clr_rd    = w_md_hs ? md_wb_rd : acc_wb_rd;

    // Registered GPR write port; address/data hold when nothing is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_en   <= 1'b0;
            rd_add     <= '0;
            data_write <= '0;
        end else begin
            write_en <= w_we;
            if (w_we) begin
                rd_add     <= w_rd;
                data_write <= w_data;
            end
        end
    end

    // Round-robin pointer moves to the other source after each grant.
    always_ff @(posedge clk) begin
        if (rst)           r_rr_ptr <= RR_MD;
        else if (w_md_hs)  r_rr_ptr <= RR_ACC;
        else if (w_acc_hs) r_rr_ptr <= RR_MD;
    end

    gpr_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_set_valid (mark_valid),
        .i_set_rd    (mark_rd),
        .i_clr_valid (w_clr_valid),
        .i_clr_rd    (w_clr_rd),
        .o_busy      (gpr_busy)
    );

    // Remember stalled MD/ACC offers so their stability can be checked.
    always_ff @(posedge clk) begin
        r_md_hold  <= ~rst & md_wb_valid & ~md_wb_ready;
        r_md_rd    <= md_wb_rd;
        r_md_data  <= md_wb_data;
        r_acc_hold <= ~rst & acc_wb_valid & ~acc_wb_ready;
        r_acc_rd   <= acc_wb_rd;
        r_acc_data <= acc_wb_data;
    end

    // Protocol checks: no WAW on busy regs, stalled offers stay stable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(alu_wb_valid && alu_wb_rd != '0
                      && gpr_busy[alu_wb_rd]))
                else $error("ALU WAW on busy rd %0d", alu_wb_rd);
            assert (!r_md_hold || (md_wb_valid
                    && md_wb_rd == r_md_rd
                    && md_wb_data == r_md_data))
                else $error("MD offer changed before accept");
            assert (!r_acc_hold || (acc_wb_valid
                    && acc_wb_rd == r_acc_rd
                    && acc_wb_data == r_acc_data))
                else $error("ACC offer changed before accept");
        end
    end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter.
// Hand-computed expectations per vector.
module tb_gpr_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        md_wb_valid;
    logic        md_wb_ready;
    logic [4:0]  md_wb_rd;
    logic [31:0] md_wb_data;
    logic        acc_wb_valid;
    logic        acc_wb_ready;
    logic [4:0]  acc_wb_rd;
    logic [31:0] acc_wb_data;
    logic        mark_valid;
    logic [4:0]  mark_rd;
    logic [31:0] gpr_busy;
    logic [4:0]  rd_add;
    logic [31:0] data_write;
    logic        write_en;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpr_wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .alu_wb_valid (alu_wb_valid),
        .alu_wb_rd    (alu_wb_rd),
        .alu_wb_data  (alu_wb_data),
        .md_wb_valid  (md_wb_valid),
        .md_wb_ready  (md_wb_ready),
        .md_wb_rd     (md_wb_rd),
        .md_wb_data   (md_wb_data),
        .acc_wb_valid (acc_wb_valid),
        .acc_wb_ready (acc_wb_ready),
        .acc_wb_rd    (acc_wb_rd),
        .acc_wb_data  (acc_wb_data),
        .mark_valid   (mark_valid),
        .mark_rd      (mark_rd),
        .gpr_busy     (gpr_busy),
        .rd_add       (rd_add),
        .data_write   (data_write),
        .write_en     (write_en)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        alu_wb_valid = 1'b1;
        alu_wb_rd    = 5'd1;
        alu_wb_data  = 32'h1;
        md_wb_valid  = 1'b1;
        md_wb_rd     = 5'd2;
        md_wb_data   = 32'h2;
        acc_wb_valid = 1'b1;
        acc_wb_rd    = 5'd4;
        acc_wb_data  = 32'h4;
        mark_valid   = 1'b1;
        mark_rd      = 5'd9;

        // reset with everything asserted
        tick();
        check("rst1_we", {31'd0, write_en}, 32'd0);
        check("rst1_busy", gpr_busy, 32'd0);
        check("rst1_mdr", {31'd0, md_wb_ready}, 32'd0);
        check("rst1_accr", {31'd0, acc_wb_ready}, 32'd0);
        tick();
        check("rst2_we", {31'd0, write_en}, 32'd0);
        check("rst2_busy", gpr_busy, 32'd0);
        check("rst2_rd", {27'd0, rd_add}, 32'd0);
        check("rst2_data", data_write, 32'd0);

        // rr pointer starts at MD
        rst          = 1'b0;
        alu_wb_valid = 1'b0;
        mark_valid   = 1'b0;
        md_wb_valid  = 1'b1;
        acc_wb_valid = 1'b1;
        settle();
        check("rr_mdr", {31'd0, md_wb_ready}, 32'd1);
        check("rr_accr", {31'd0, acc_wb_ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst          = 1'b0;
        md_wb_valid  = 1'b0;
        acc_wb_valid = 1'b0;
        tick();

        // single ALU write
        alu_wb_valid = 1'b1;
        alu_wb_rd    = 5'd3;
        alu_wb_data  = 32'hABCDEF01;
        tick();
        alu_wb_valid = 1'b0;
        check("alu_we", {31'd0, write_en}, 32'd1);
        check("alu_rd", {27'd0, rd_add}, 32'd3);
        check("alu_data", data_write, 32'hABCDEF01);
        tick();
        check("alu_we_off", {31'd0, write_en}, 32'd0);
        check("alu_rd_hold", {27'd0, rd_add}, 32'd3);

        // mark 5 and 6, then ALU + MD + ACC together
        mark_valid = 1'b1;
        mark_rd    = 5'd5;
        tick();
        mark_rd = 5'd6;
        tick();
        mark_valid = 1'b0;
        check("mark_busy", gpr_busy, 32'h0000_0060);
        alu_wb_valid = 1'b1;
        alu_wb_rd    = 5'd9;
        alu_wb_data  = 32'h99;
        md_wb_valid  = 1'b1;
        md_wb_rd     = 5'd5;
        md_wb_data   = 32'h11;
        acc_wb_valid = 1'b1;
        acc_wb_rd    = 5'd6;
        acc_wb_data  = 32'h22;
        settle();
        check("mix_mdr_alu", {31'd0, md_wb_ready}, 32'd0);
        check("mix_accr_alu", {31'd0, acc_wb_ready}, 32'd0);
        tick();
        alu_wb_valid = 1'b0;
        check("mix_alu_rd", {27'd0, rd_add}, 32'd9);
        check("mix_alu_data", data_write, 32'h99);
        check("mix_alu_busy", gpr_busy, 32'h0000_0060);
        settle();
        check("mix_mdr", {31'd0, md_wb_ready}, 32'd1);
        check("mix_accr", {31'd0, acc_wb_ready}, 32'd0);
        tick();
        md_wb_valid = 1'b0;
        check("mix_md_we", {31'd0, write_en}, 32'd1);
        check("mix_md_rd", {27'd0, rd_add}, 32'd5);
        check("mix_md_data", data_write, 32'h11);
        check("mix_md_busy", gpr_busy, 32'h0000_0040);
        tick();
        acc_wb_valid = 1'b0;
        check("mix_acc_we", {31'd0, write_en}, 32'd1);
        check("mix_acc_rd", {27'd0, rd_add}, 32'd6);
        check("mix_acc_data", data_write, 32'h22);
        check("mix_acc_busy", gpr_busy, 32'd0);
        tick();
        check("mix_idle_we", {31'd0, write_en}, 32'd0);

        // MD/ACC contention alternates
        md_wb_valid  = 1'b1;
        md_wb_rd     = 5'd10;
        md_wb_data   = 32'hA1;
        acc_wb_valid = 1'b1;
        acc_wb_rd    = 5'd12;
        acc_wb_data  = 32'hB1;
        tick();
        md_wb_rd   = 5'd11;
        md_wb_data = 32'hA2;
        check("rr1_rd", {27'd0, rd_add}, 32'd10);
        check("rr1_data", data_write, 32'hA1);
        tick();
        acc_wb_rd   = 5'd13;
        acc_wb_data = 32'hB2;
        check("rr2_rd", {27'd0, rd_add}, 32'd12);
        check("rr2_data", data_write, 32'hB1);
        tick();
        md_wb_valid = 1'b0;
        check("rr3_rd", {27'd0, rd_add}, 32'd11);
        check("rr3_data", data_write, 32'hA2);
        tick();
        acc_wb_valid = 1'b0;
        check("rr4_rd", {27'd0, rd_add}, 32'd13);
        check("rr4_data", data_write, 32'hB2);
        check("rr4_we", {31'd0, write_en}, 32'd1);

        // MD to x0: accepted, never written
        md_wb_valid = 1'b1;
        md_wb_rd    = 5'd0;
        md_wb_data  = 32'hFFFF;
        settle();
        check("x0_mdr", {31'd0, md_wb_ready}, 32'd1);
        tick();
        md_wb_valid = 1'b0;
        check("x0_we", {31'd0, write_en}, 32'd0);
        check("x0_rd_hold", {27'd0, rd_add}, 32'd13);

        // mark x0 leaves busy unchanged
        mark_valid = 1'b1;
        mark_rd    = 5'd8;
        tick();
        mark_rd = 5'd0;
        tick();
        mark_valid = 1'b0;
        check("x0_mark", gpr_busy, 32'h0000_0100);

        // rr now at ACC: acc clears 8
        acc_wb_valid = 1'b1;
        acc_wb_rd    = 5'd8;
        acc_wb_data  = 32'h88;
        md_wb_valid  = 1'b1;
        md_wb_rd     = 5'd14;
        md_wb_data   = 32'hE;
        settle();
        check("p_accr", {31'd0, acc_wb_ready}, 32'd1);
        check("p_mdr", {31'd0, md_wb_ready}, 32'd0);
        tick();
        acc_wb_valid = 1'b0;
        check("p_acc_rd", {27'd0, rd_add}, 32'd8);
        check("p_busy", gpr_busy, 32'd0);
        tick();
        md_wb_valid = 1'b0;
        check("p_md_rd", {27'd0, rd_add}, 32'd14);

        // same-cycle set and clear of rd 7: set wins
        mark_valid = 1'b1;
        mark_rd    = 5'd7;
        tick();
        md_wb_valid = 1'b1;
        md_wb_rd    = 5'd7;
        md_wb_data  = 32'h77;
        tick();
        md_wb_valid = 1'b0;
        mark_valid  = 1'b0;
        check("sw_busy", gpr_busy, 32'h0000_0080);
        check("sw_rd", {27'd0, rd_add}, 32'd7);
        check("sw_data", data_write, 32'h77);

        // reset while MD waits behind ALU
        alu_wb_valid = 1'b1;
        alu_wb_rd    = 5'd2;
        alu_wb_data  = 32'h2222;
        md_wb_valid  = 1'b1;
        md_wb_rd     = 5'd7;
        md_wb_data   = 32'h7777;
        tick();
        check("mw_rd", {27'd0, rd_add}, 32'd2);
        rst = 1'b1;
        tick();
        check("mw_busy", gpr_busy, 32'd0);
        check("mw_we", {31'd0, write_en}, 32'd0);
        check("mw_data", data_write, 32'd0);
        rst          = 1'b0;
        alu_wb_valid = 1'b0;
        md_wb_valid  = 1'b0;
        tick();
        check("post_busy", gpr_busy, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
